// File: rtl/fw_ip_cfg_shifter.sv
// Firmware-driven serial configuration shifter: shadows a CFG_BITS chain in 16-bit words,
// shifts it MSB first with a programmable half-period divider, and captures serial readback.
module fw_ip_cfg_shifter #(
    parameter int CFG_BITS  = 768,
    parameter int NUM_WORDS = (CFG_BITS + 15) / 16
) (
    input  logic        fw_clk,
    input  logic        fw_rst,
    input  logic        fw_dev_id_enable,
    input  logic        fw_op_code_w_reset,
    input  logic        fw_op_code_w_cfg_array_0,
    input  logic        fw_op_code_r_cfg_array_0,
    input  logic        fw_op_code_w_status_clear,
    input  logic        fw_op_code_w_execute,
    input  logic [23:0] sw_write24_0,
    output logic [31:0] fw_read_data32,
    output logic [31:0] fw_read_status32,
    output logic        fw_config_clk,
    output logic        fw_config_in,
    output logic        fw_config_load,
    output logic        fw_reset_not,
    input  logic        fw_config_out
);
    localparam int FW  = NUM_WORDS * 16;
    localparam int IW  = $clog2(FW);
    localparam int WIW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [15:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]      half_q, half_d;
    logic [8:0]      ph_cnt_q, ph_cnt_d;
    logic [FW-1:0]   shadow_q, shadow_d;
    logic [FW-1:0]   rb_q, rb_d;
    logic [31:0]     rd_q, rd_d;
    logic            done_q, done_d, err_q, err_d;
    logic            cclk_q, cclk_d, cin_q, cin_d, cload_q, cload_d, rstn_q, rstn_d;

    logic            op_rst, op_w, op_r, op_clr, op_exe;
    logic            busy, idx_ok, done_set, err_set;
    logic [WIW-1:0]  widx;
    logic [7:0]      half_new;
    logic [IW-1:0]   cur_idx, nxt_idx;

    always_comb begin
        op_rst   = fw_dev_id_enable & fw_op_code_w_reset;
        op_w     = fw_dev_id_enable & fw_op_code_w_cfg_array_0;
        op_r     = fw_dev_id_enable & fw_op_code_r_cfg_array_0;
        op_clr   = fw_dev_id_enable & fw_op_code_w_status_clear;
        op_exe   = fw_dev_id_enable & fw_op_code_w_execute & ~op_rst;
        busy     = (state_q != IDLE);
        idx_ok   = (32'(sw_write24_0[23:16]) < NUM_WORDS);
        widx     = WIW'(sw_write24_0[23:16]);
        half_new = (sw_write24_0[7:0] == 8'h0) ? 8'h1 : sw_write24_0[7:0];
        cur_idx  = IW'(bit_cnt_q - 16'd1);

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        half_d    = half_q;
        ph_cnt_d  = ph_cnt_q;
        shadow_d  = shadow_q;
        rb_d      = rb_q;
        rd_d      = rd_q;
        rstn_d    = rstn_q;
        done_set  = 1'b0;
        err_set   = 1'b0;

        if (op_w) begin
            if (busy || !idx_ok) err_set = 1'b1;
            else shadow_d[{widx, 4'h0} +: 16] = sw_write24_0[15:0];
        end
        if (op_r) begin
            if (idx_ok) rd_d = {16'h0, rb_q[{widx, 4'h0} +: 16]};
            else begin
                rd_d    = 32'h0;
                err_set = 1'b1;
            end
        end
        if (op_exe && busy) err_set = 1'b1;

        // ph_cnt holds the remaining cycles of the current phase minus one
        case (state_q)
            IDLE: if (op_exe) begin
                state_d   = SHIFT_LO;
                half_d    = half_new;
                bit_cnt_d = 16'(CFG_BITS);
                ph_cnt_d  = {1'b0, half_new} - 9'd1;
            end
            SHIFT_LO: if (ph_cnt_q == 9'd0) begin
                state_d       = SHIFT_HI;
                ph_cnt_d      = {1'b0, half_q} - 9'd1;
                rb_d[cur_idx] = fw_config_out;
            end else ph_cnt_d = ph_cnt_q - 9'd1;
            SHIFT_HI: if (ph_cnt_q == 9'd0) begin
                bit_cnt_d = bit_cnt_q - 16'd1;
                if (bit_cnt_d == 16'd0) begin
                    state_d  = LOAD;
                    ph_cnt_d = {half_q, 1'b0} - 9'd1;
                end else begin
                    state_d  = SHIFT_LO;
                    ph_cnt_d = {1'b0, half_q} - 9'd1;
                end
            end else ph_cnt_d = ph_cnt_q - 9'd1;
            LOAD: if (ph_cnt_q == 9'd0) begin
                state_d  = DONE;
                done_set = 1'b1;
            end else ph_cnt_d = ph_cnt_q - 9'd1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (op_rst) begin
            state_d  = IDLE;
            done_set = 1'b0;
            rstn_d   = sw_write24_0[0];
        end

        done_d  = done_set | (done_q & ~op_clr);
        err_d   = err_set  | (err_q  & ~op_clr);
        nxt_idx = IW'(bit_cnt_d - 16'd1);
        cclk_d  = (state_d == SHIFT_HI);
        cload_d = (state_d == LOAD);
        cin_d   = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? shadow_q[nxt_idx] : 1'b0;
    end

    always_ff @(posedge fw_clk or posedge fw_rst) begin
        if (fw_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            half_q    <= '0;
            ph_cnt_q  <= '0;
            shadow_q  <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cclk_q    <= 1'b0;
            cin_q     <= 1'b0;
            cload_q   <= 1'b0;
            rstn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            half_q    <= half_d;
            ph_cnt_q  <= ph_cnt_d;
            shadow_q  <= shadow_d;
            rb_q      <= rb_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cclk_q    <= cclk_d;
            cin_q     <= cin_d;
            cload_q   <= cload_d;
            rstn_q    <= rstn_d;
        end
    end

    assign fw_read_data32   = rd_q;
    assign fw_read_status32 = {(state_q != IDLE), done_q, err_q, 5'b0, half_q, bit_cnt_q};
    assign fw_config_clk    = cclk_q;
    assign fw_config_in     = cin_q;
    assign fw_config_load   = cload_q;
    assign fw_reset_not     = rstn_q;
endmodule

// File: tb/tb_fw_ip_cfg_shifter.sv
// Bench for fw_ip_cfg_shifter at CFG_BITS=32 with the config chain looped back through a
// one-clock delay; op vectors from a table, shift runs checked against a behavioural model.
module tb_fw_ip_cfg_shifter;
    localparam int OP_RST = 0, OP_W = 1, OP_R = 2, OP_CLR = 3, OP_EXE = 4;
    localparam int TMO = 2000;

    logic        fw_clk = 1'b0, fw_rst = 1'b1, en = 1'b1;
    logic        s_rst = 1'b0, s_w = 1'b0, s_r = 1'b0, s_clr = 1'b0, s_exe = 1'b0;
    logic [23:0] arg = '0;
    logic [31:0] rd, st;
    logic        cclk, cin, cload, rstn, cout_q;

    int          nvec = 0, nmis = 0;
    int          load_cnt = 0, nrise = 0, period = 0, last_rise = 0, cyc_g = 0;
    logic [31:0] stream = '0;
    logic        prev_cclk = 1'b0;

    fw_ip_cfg_shifter #(.CFG_BITS(32)) dut (
        .fw_clk(fw_clk), .fw_rst(fw_rst), .fw_dev_id_enable(en),
        .fw_op_code_w_reset(s_rst), .fw_op_code_w_cfg_array_0(s_w),
        .fw_op_code_r_cfg_array_0(s_r), .fw_op_code_w_status_clear(s_clr),
        .fw_op_code_w_execute(s_exe), .sw_write24_0(arg),
        .fw_read_data32(rd), .fw_read_status32(st),
        .fw_config_clk(cclk), .fw_config_in(cin), .fw_config_load(cload),
        .fw_reset_not(rstn), .fw_config_out(cout_q)
    );

    always #5 fw_clk = ~fw_clk;
    always @(posedge fw_clk) cout_q <= cin;

    // Observe the serial pins: clock period, load width, and the bit stream at each rising config clock
    initial forever begin
        @(posedge fw_clk); #1;
        cyc_g++;
        if (cload) load_cnt++;
        if (cclk && !prev_cclk) begin
            if (nrise > 0) period = cyc_g - last_rise;
            last_rise = cyc_g;
            nrise++;
            stream = {stream[30:0], cin};
        end
        prev_cclk = cclk;
    end

    task automatic tick; @(posedge fw_clk); #1; endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_op(input int op, input logic [23:0] a, input logic e);
        en = e; arg = a;
        s_rst = (op == OP_RST); s_w = (op == OP_W); s_r = (op == OP_R);
        s_clr = (op == OP_CLR); s_exe = (op == OP_EXE);
        tick;
        s_rst = 0; s_w = 0; s_r = 0; s_clr = 0; s_exe = 0; en = 1; arg = '0;
    endtask

    task automatic read_rb(output logic [31:0] r);
        do_op(OP_R, 24'h000000, 1'b1); r[15:0]  = rd[15:0];
        do_op(OP_R, 24'h010000, 1'b1); r[31:16] = rd[15:0];
    endtask

    // Cycle count from the execute strobe: the edge that samples it is cycle 1
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (st[30] !== 1'b1 && cyc < TMO) begin tick; cyc++; end
    endtask

    task automatic run_exe(input logic [7:0] h, output int cyc);
        do_op(OP_CLR, 24'h0, 1'b1);
        nrise = 0; load_cnt = 0; stream = '0; period = 0;
        do_op(OP_EXE, {16'h0, h}, 1'b1);
        wait_done(cyc);
    endtask

    task automatic wait_bitcnt(input int n);
        int c = 0;
        while (st[15:0] != 16'(n) && c < TMO) begin tick; c++; end
        chk("reach_bitcnt", st[15:0], 32'(n));
    endtask

    function automatic int model_lat(input int h);
        int he = (h == 0) ? 1 : h;
        return 1 + 2 * he * 32 + 2 * he;
    endfunction

    // With HALF=1 the looped-back bit arrives one bit late; slower clocks sample the bit itself
    function automatic logic [31:0] model_rb(input logic [31:0] sh, input int h);
        return (h <= 1) ? (sh >> 1) : sh;
    endfunction

    typedef struct {
        int          op;
        logic [23:0] a;
        logic        e;
        logic [31:0] rd;
        logic [2:0]  st3;
        logic        rn;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int          cyc;
        logic [31:0] r, sh;
        logic [7:0]  h;

        tbl[0]  = '{OP_W,   24'h00A5C3, 1'b1, 32'h0, 3'b000, 1'b0};
        tbl[1]  = '{OP_W,   24'h010F0F, 1'b1, 32'h0, 3'b000, 1'b0};
        tbl[2]  = '{OP_R,   24'h000000, 1'b1, 32'h0, 3'b000, 1'b0};
        tbl[3]  = '{OP_W,   24'h02FFFF, 1'b1, 32'h0, 3'b001, 1'b0};
        tbl[4]  = '{OP_CLR, 24'h000000, 1'b1, 32'h0, 3'b000, 1'b0};
        tbl[5]  = '{OP_R,   24'h020000, 1'b1, 32'h0, 3'b001, 1'b0};
        tbl[6]  = '{OP_CLR, 24'h000000, 1'b1, 32'h0, 3'b000, 1'b0};
        tbl[7]  = '{OP_RST, 24'h000001, 1'b1, 32'h0, 3'b000, 1'b1};
        tbl[8]  = '{OP_W,   24'h00FFFF, 1'b0, 32'h0, 3'b000, 1'b1};
        tbl[9]  = '{OP_RST, 24'h000000, 1'b0, 32'h0, 3'b000, 1'b1};
        tbl[10] = '{OP_EXE, 24'h000001, 1'b0, 32'h0, 3'b000, 1'b1};

        tick;
        chk("rst_status", st, 32'h0);
        chk("rst_rdata", rd, 32'h0);
        chk("rst_pins", {28'h0, cclk, cin, cload, rstn}, 32'h0);
        fw_rst = 1'b0;
        tick;

        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].e);
            chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_st", i), 32'(st[31:29]), 32'(tbl[i].st3));
            chk($sformatf("vec%0d_rn", i), 32'(rstn), 32'(tbl[i].rn));
        end

        sh = 32'h0F0FA5C3;
        run_exe(8'd1, cyc);
        chk("lb_latency", cyc, 67);
        chk("lb_status", st, {3'b110, 5'b0, 8'd1, 16'd0});
        chk("lb_stream", stream, sh);
        chk("lb_period", period, 2);
        chk("lb_load", load_cnt, 2);
        tick;
        chk("lb_idle", 32'(st[31]), 32'h0);
        read_rb(r);
        chk("lb_readback", r, model_rb(sh, 1));

        run_exe(8'd0, cyc);
        chk("div0_latency", cyc, model_lat(0));
        chk("div0_half", 32'(st[23:16]), 32'd1);
        chk("div0_period", period, 2);
        chk("div0_load", load_cnt, 2);
        run_exe(8'd3, cyc);
        chk("div3_latency", cyc, model_lat(3));
        chk("div3_half", 32'(st[23:16]), 32'd3);
        chk("div3_period", period, 6);
        chk("div3_load", load_cnt, 6);
        tick;
        read_rb(r);
        chk("div3_readback", r, model_rb(sh, 3));

        do_op(OP_CLR, 24'h0, 1'b1);
        nrise = 0;
        do_op(OP_EXE, 24'h000001, 1'b1);
        wait_bitcnt(20);
        do_op(OP_W, 24'h00FFFF, 1'b1);
        chk("busy_w_err", 32'(st[29]), 32'h1);
        do_op(OP_EXE, 24'h000001, 1'b1);
        wait_done(cyc);
        chk("busy_done", 32'(st[30]), 32'h1);
        repeat (80) tick;
        chk("busy_one_seq", nrise, 32);
        chk("busy_flags", 32'(st[31:29]), 32'b011);
        read_rb(r);
        chk("busy_shadow_kept", r, model_rb(sh, 1));
        do_op(OP_CLR, 24'h0, 1'b1);
        chk("busy_clr", 32'(st[31:29]), 32'b000);

        do_op(OP_RST, 24'h000000, 1'b1);
        do_op(OP_EXE, 24'h000001, 1'b1);
        wait_bitcnt(10);
        do_op(OP_RST, 24'h000001, 1'b1);
        chk("abort_flags", 32'(st[31:30]), 32'b00);
        chk("abort_pins", {28'h0, cclk, cin, cload, rstn}, 32'h1);
        run_exe(8'd1, cyc);
        chk("abort_rerun_lat", cyc, 67);
        tick;
        read_rb(r);
        chk("abort_rerun_rb", r, model_rb(sh, 1));

        for (int n = 0; n < 6; n++) begin
            sh = $urandom;
            h  = 8'($urandom_range(0, 3));
            do_op(OP_W, {8'h00, sh[15:0]}, 1'b1);
            do_op(OP_W, {8'h01, sh[31:16]}, 1'b1);
            run_exe(h, cyc);
            chk($sformatf("rnd%0d_lat", n), cyc, model_lat(int'(h)));
            chk($sformatf("rnd%0d_stream", n), stream, sh);
            tick;
            read_rb(r);
            chk($sformatf("rnd%0d_rb", n), r, model_rb(sh, int'(h)));
        end

        do_op(OP_CLR, 24'h0, 1'b1);
        do_op(OP_EXE, 24'h000003, 1'b1);
        cyc = 0;
        while (cload !== 1'b1 && cyc < TMO) begin tick; cyc++; end
        chk("arst_in_load", 32'(cload), 32'h1);
        #2 fw_rst = 1'b1;
        #1;
        chk("arst_load", 32'(cload), 32'h0);
        chk("arst_status", st, 32'h0);
        chk("arst_rdata", rd, 32'h0);
        chk("arst_pins", {28'h0, cclk, cin, cload, rstn}, 32'h0);
        #2 fw_rst = 1'b0;
        tick;
        chk("arst_after", st, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/fw_ip_cfg_shifter.md
FW_IP_CFG_SHIFTER -- requirements
Module: fw_ip_cfg_shifter

Interface
REQ-001 Parameter CFG_BITS, default 768: DUT configuration chain length in bits, legal range 16..4096.
REQ-002 Parameter NUM_WORDS, default ceil(CFG_BITS/16): number of 16-bit shadow/readback words, at most 256.
REQ-003 fw_clk  in  1  FW clock, mapped to S_AXI_ACLK; all logic rising-edge.
REQ-004 fw_rst  in  1  reset, asynchronous, active-high.
REQ-005 fw_dev_id_enable  in  1  qualifies every op code; op codes are ignored while low.
REQ-006 fw_op_code_w_reset, fw_op_code_w_cfg_array_0, fw_op_code_r_cfg_array_0, fw_op_code_w_status_clear, fw_op_code_w_execute  in  1 each  single-cycle op-code strobes.
REQ-007 sw_write24_0  in  24  SW operand: [23:16] word index, [15:0] data; for execute, [7:0] is HALF; for w_reset, [0] is the reset_not level.
REQ-008 fw_read_data32  out  32  read data to SW.
REQ-009 fw_read_status32  out  32  status to SW.
REQ-010 fw_config_clk, fw_config_in, fw_config_load, fw_reset_not  out  1 each  DUT configuration pins.
REQ-011 fw_config_out  in  1  serial readback from the DUT chain.

Function
REQ-012 w_cfg_array_0 while IDLE: shadow[idx] <= data; an idx >= NUM_WORDS is dropped and sets err.
REQ-013 r_cfg_array_0: the next cycle, fw_read_data32 = {16'h0, readback[idx]}; idx >= NUM_WORDS returns 0 and sets err; the value holds until the next read.
REQ-014 Chain bit k maps to shadow[k/16][k%16]; bit CFG_BITS-1 shifts first (MSB first); unused bits of the last word are never shifted.
REQ-015 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
REQ-016 Execute in IDLE latches HALF (0 is treated as 1), loads bit_cnt = CFG_BITS, and enters SHIFT_LO on the next cycle.
REQ-017 SHIFT_LO: fw_config_clk = 0; fw_config_in presents the current bit for HALF cycles; then go to SHIFT_HI.
REQ-018 SHIFT_HI: fw_config_clk = 1 for HALF cycles.
REQ-019 On the SHIFT_LO->SHIFT_HI edge, fw_config_out is sampled into readback bit (bit_cnt-1), using the same mapping as REQ-014.
REQ-020 Exiting SHIFT_HI decrements bit_cnt; if the result is 0, go to LOAD, otherwise go to SHIFT_LO.
REQ-021 LOAD: fw_config_clk = 0 and fw_config_in = 0; fw_config_load = 1 for 2*HALF cycles; then go to DONE.
REQ-022 DONE: set done, go to IDLE after one cycle.
REQ-023 Total execute latency, strobe to DONE entry, is 1 + 2*HALF*CFG_BITS + 2*HALF cycles.
REQ-024 fw_read_status32 = {busy, done, err, 5'b0, 8'(HALF latched), 16'(bit_cnt)}; busy = (state != IDLE).
REQ-025 Execute or w_cfg_array_0 while busy: ignored, err set; r_cfg_array_0 while busy is allowed and returns partial readback.
REQ-026 w_status_clear clears done and err.
REQ-027 If w_status_clear coincides with an event that sets done or err, the set wins.
REQ-028 w_reset: fw_reset_not <= sw_write24_0[0]; abort any shift.
REQ-029 After a w_reset abort: state goes to IDLE and config_clk/in/load go to 0 on the next cycle; the shadow is kept; the readback is kept, partial; done is not set.
REQ-030 If w_reset and execute strobe in the same cycle, w_reset wins and execute is dropped without setting err.
REQ-031 All DUT outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-032 fw_rst asserted: state IDLE; fw_config_clk = fw_config_in = fw_config_load = 0; fw_reset_not = 0 (DUT held in reset).
REQ-033 fw_rst asserted: fw_read_data32 = 0; fw_read_status32 = 0; shadow and readback = 0; bit_cnt = 0.
REQ-034 fw_rst asserted mid-shift: all of REQ-032..033 apply immediately and asynchronously; the bench checks this within the same cycle.

Verification (CFG_BITS=32)
REQ-035 Loopback: write word0 = 16'hA5C3, word1 = 16'h0F0F; tie config_out to config_in delayed by one DUT clock; execute HALF = 1.
  - DONE occurs at cycle 1 + 64 + 2.
  - Serial stream is 0F0F then A5C3, MSB first.
  - Readback matches shadow shifted by one bit.
REQ-036 Divider: execute with HALF = 0 and with HALF = 3.
  - Config_clk period is 2 and 6 cycles respectively.
  - Status[23:16] reads 1 and 3 respectively.
  - Load pulse width is 2 and 6 cycles respectively.
REQ-037 Busy protection: execute, then write word0 = 16'hFFFF at bit_cnt = 20, then a second execute.
  - Err = 1; shadow unchanged; only one shift sequence runs.
  - Status_clear then leaves done = 1 cleared and err = 0.
REQ-038 Abort: w_reset with operand 1 at bit_cnt = 10.
  - The next cycle: busy = 0, done = 0, fw_reset_not = 1, config pins 0.
  - A following execute completes normally.
REQ-039 Out-of-range: write and read idx = 2 (NUM_WORDS = 2) -> read data 0 and err = 1; dev_id_enable = 0 with any strobe -> no state change.
REQ-040 Async reset asserted mid-LOAD -> config_load = 0 and status = 0 before the next fw_clk edge.
